// File: rtl/otter_wb_arbiter.sv
// Register-file write-back arbiter for the Otter core.
// Merges a never-stalled ALU result stream with a load-result stream.
// Loads are formatted (byte/half/word, sign/zero extension) on acceptance,
// buffered in a 2-entry FIFO whenever the write port is busy, and drained
// in acceptance order. A hazard query reports whether a register still
// has a write in flight, either in the FIFO or in the output register.
module otter_wb_arbiter (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_alu_valid,
   input  logic [4:0]  i_alu_rd,
   input  logic [31:0] i_alu_data,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  logic [4:0]  i_ld_rd,
   input  logic [31:0] i_ld_word,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_offset,
   output logic        o_w_en,
   output logic [4:0]  o_w_addr,
   output logic [31:0] o_w_data,
   input  logic [4:0]  i_q_addr,
   output logic        o_q_pending
);

   logic [4:0]  fifo_rd   [2];
   logic [31:0] fifo_data [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   logic        fifo_empty;
   logic        ld_accept;
   logic        ld_push;
   logic        fifo_pop;

   logic        sel_valid;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;

   logic        head_hit;
   logic        tail_hit;
   logic        out_hit;

   // Ready depends only on the registered count, so no input reaches it.
   assign o_ld_ready = (count != 2'd2);
   assign fifo_empty = (count == 2'd0);
   assign ld_accept  = i_ld_valid && o_ld_ready;
   // ALU owns the port when valid; otherwise the FIFO head goes first.
   assign fifo_pop   = !i_alu_valid && !fifo_empty;
   // A load is buffered unless it can take the port straight away.
   assign ld_push    = ld_accept && (i_alu_valid || !fifo_empty);

   // Format the incoming load word into its register value.
   always_comb begin
      ld_byte = i_ld_word[7:0];
      case (i_ld_offset)
         2'd0:    ld_byte = i_ld_word[7:0];
         2'd1:    ld_byte = i_ld_word[15:8];
         2'd2:    ld_byte = i_ld_word[23:16];
         default: ld_byte = i_ld_word[31:24];
      endcase
      // Halfword selection ignores offset[0]; misaligned halves are not split.
      ld_half = i_ld_offset[1] ? i_ld_word[31:16] : i_ld_word[15:0];
      case (i_ld_funct3)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'h0, ld_byte};
         3'b101:  ld_fmt = {16'h0, ld_half};
         default: ld_fmt = i_ld_word;
      endcase
   end

   // Pick this cycle's write source: ALU, then FIFO head, then bypassed load.
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = 5'd0;
      sel_data  = 32'h0;
      if (i_alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = i_alu_rd;
         sel_data  = i_alu_data;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_rd[rd_ptr];
         sel_data  = fifo_data[rd_ptr];
      end else if (ld_accept) begin
         sel_valid = 1'b1;
         sel_rd    = i_ld_rd;
         sel_data  = ld_fmt;
      end
   end

   // Output register; x0 results are consumed but never written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_w_en   <= 1'b0;
         o_w_addr <= 5'd0;
         o_w_data <= 32'h0;
      end else begin
         o_w_en <= sel_valid && (sel_rd != 5'd0);
         if (sel_valid) begin
            o_w_addr <= sel_rd;
            o_w_data <= sel_data;
         end
      end
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (ld_push)
            wr_ptr <= ~wr_ptr;
         if (fifo_pop)
            rd_ptr <= ~rd_ptr;
         case ({ld_push, fifo_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are only meaningful under the count, so no reset.
   always_ff @(posedge i_clk) begin
      if (ld_push) begin
         fifo_rd[wr_ptr]   <= i_ld_rd;
         fifo_data[wr_ptr] <= ld_fmt;
      end
   end

   // Hazard query: head is live with one entry, both entries live when full.
   assign head_hit    = (count != 2'd0) && (fifo_rd[rd_ptr] == i_q_addr);
   assign tail_hit    = (count == 2'd2) && (fifo_rd[~rd_ptr] == i_q_addr);
   assign out_hit     = o_w_en && (o_w_addr == i_q_addr);
   assign o_q_pending = (i_q_addr != 5'd0) && (head_hit || tail_hit || out_hit);

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Directed and randomized bench for the write-back arbiter.
module tb_otter_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_word;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_offset;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [4:0]  q_addr;
   logic        q_pending;

   int errors = 0;
   int checks = 0;

   logic [36:0] exp_q [$];
   logic        p_alu_v;
   logic [4:0]  p_alu_rd;
   logic [31:0] p_alu_data;
   logic [36:0] front;

   otter_wb_arbiter dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_alu_valid (alu_valid),
      .i_alu_rd    (alu_rd),
      .i_alu_data  (alu_data),
      .i_ld_valid  (ld_valid),
      .o_ld_ready  (ld_ready),
      .i_ld_rd     (ld_rd),
      .i_ld_word   (ld_word),
      .i_ld_funct3 (ld_funct3),
      .i_ld_offset (ld_offset),
      .o_w_en      (w_en),
      .o_w_addr    (w_addr),
      .o_w_data    (w_data),
      .i_q_addr    (q_addr),
      .o_q_pending (q_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] w,
                         input logic [2:0] f3, input logic [1:0] off);
      ld_valid  = v;
      ld_rd     = rd;
      ld_word   = w;
      ld_funct3 = f3;
      ld_offset = off;
   endtask

   // Reference load formatting built from shifts rather than slice muxes.
   function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] w,
                                       input logic [1:0] off);
      logic [31:0] sb;
      logic [31:0] sh;
      sb = w >> (8 * off);
      sh = w >> (off[1] ? 16 : 0);
      case (f3)
         3'b000:  fmt = {{24{sb[7]}}, sb[7:0]};
         3'b001:  fmt = {{16{sh[15]}}, sh[15:0]};
         3'b100:  fmt = sb & 32'h0000_00FF;
         3'b101:  fmt = sh & 32'h0000_FFFF;
         default: fmt = w;
      endcase
   endfunction

   // Scoreboard check of one output cycle during random traffic.
   task automatic rnd_check();
      if (p_alu_v) begin
         chk("rnd_alu_en", w_en, (p_alu_rd != 5'd0));
         if (p_alu_rd != 5'd0) begin
            chk("rnd_alu_addr", w_addr, p_alu_rd);
            chk("rnd_alu_data", w_data, p_alu_data);
         end
      end else if (w_en) begin
         if (exp_q.size() == 0) begin
            chk("rnd_spurious_write", w_en, 1'b0);
         end else begin
            front = exp_q.pop_front();
            chk("rnd_ld_addr", w_addr, front[36:32]);
            chk("rnd_ld_data", w_data, front[31:0]);
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      q_addr = 5'd1;
      set_alu(1'b0, 5'd0, 32'h0);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      #2;
      chk("rst_w_en", w_en, 1'b0);
      chk("rst_w_addr", w_addr, 5'd0);
      chk("rst_w_data", w_data, 32'h0);
      chk("rst_ready", ld_ready, 1'b1);
      chk("rst_pending", q_pending, 1'b0);
      tick();
      rst_n = 1'b1;

      // ALU write, then idle
      set_alu(1'b1, 5'd1, 32'hDEAD_BEEF);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("alu_en", w_en, 1'b1);
      chk("alu_addr", w_addr, 5'd1);
      chk("alu_data", w_data, 32'hDEAD_BEEF);
      chk("alu_pending_x1", q_pending, 1'b1);
      tick();
      chk("idle_en", w_en, 1'b0);
      chk("idle_addr_hold", w_addr, 5'd1);
      chk("idle_data_hold", w_data, 32'hDEAD_BEEF);

      // Load bypass formatting
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b000, 2'd3);
      tick();
      chk("lb_en", w_en, 1'b1);
      chk("lb_addr", w_addr, 5'd5);
      chk("lb_off3", w_data, 32'hFFFF_FF88);
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b100, 2'd3);
      tick();
      chk("lbu_off3", w_data, 32'h0000_0088);
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b101, 2'd2);
      tick();
      chk("lhu_off2", w_data, 32'h0000_8899);
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b001, 2'd0);
      tick();
      chk("lh_off0", w_data, 32'hFFFF_AABB);
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b000, 2'd1);
      tick();
      chk("lb_off1", w_data, 32'hFFFF_FFAA);
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b101, 2'd1);
      tick();
      chk("lhu_off1", w_data, 32'h0000_AABB);
      set_ld(1'b1, 5'd5, 32'h8899_AABB, 3'b011, 2'd2);
      tick();
      chk("f3_011_as_lw", w_data, 32'h8899_AABB);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      tick();
      chk("ld_idle_en", w_en, 1'b0);

      // ALU stream with loads queued behind it
      set_alu(1'b1, 5'd2, 32'h0000_0002);
      set_ld(1'b1, 5'd6, 32'h0000_0011, 3'b010, 2'd0);
      chk("q_ready_a", ld_ready, 1'b1);
      tick();
      chk("q_w_x2", w_addr, 5'd2);
      chk("q_ready_one", ld_ready, 1'b1);
      q_addr = 5'd6;
      #1;
      chk("q_pending_x6", q_pending, 1'b1);
      set_alu(1'b1, 5'd3, 32'h0000_0003);
      set_ld(1'b1, 5'd7, 32'h0000_0022, 3'b010, 2'd0);
      tick();
      chk("q_w_x3", w_addr, 5'd3);
      chk("q_ready_full", ld_ready, 1'b0);
      set_alu(1'b1, 5'd4, 32'h0000_0004);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      tick();
      chk("q_w_x4", w_addr, 5'd4);
      chk("q_ready_full2", ld_ready, 1'b0);
      q_addr = 5'd7;
      #1;
      chk("q_pending_x7", q_pending, 1'b1);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      chk("q_w_x6_en", w_en, 1'b1);
      chk("q_w_x6", w_addr, 5'd6);
      chk("q_d_x6", w_data, 32'h0000_0011);
      chk("q_ready_pop", ld_ready, 1'b1);
      tick();
      chk("q_w_x7", w_addr, 5'd7);
      chk("q_d_x7", w_data, 32'h0000_0022);
      q_addr = 5'd6;
      #1;
      chk("q_pending_x6_done", q_pending, 1'b0);
      tick();
      chk("q_drained_en", w_en, 1'b0);

      // x0 results are consumed silently
      set_alu(1'b1, 5'd0, 32'h0000_1234);
      set_ld(1'b1, 5'd0, 32'h0000_5555, 3'b010, 2'd0);
      q_addr = 5'd0;
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      chk("x0_alu_en", w_en, 1'b0);
      chk("x0_pending", q_pending, 1'b0);
      tick();
      chk("x0_pop_en", w_en, 1'b0);
      chk("x0_ready", ld_ready, 1'b1);
      set_ld(1'b1, 5'd9, 32'h0000_0099, 3'b010, 2'd0);
      tick();
      chk("x0_empty_bypass_en", w_en, 1'b1);
      chk("x0_empty_bypass", w_addr, 5'd9);

      // Simultaneous pop and push
      set_alu(1'b1, 5'd14, 32'h0000_0014);
      set_ld(1'b1, 5'd15, 32'h0000_0001, 3'b010, 2'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      set_ld(1'b1, 5'd16, 32'h0000_0002, 3'b010, 2'd0);
      tick();
      chk("pp_x15", w_addr, 5'd15);
      chk("pp_ready", ld_ready, 1'b1);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      tick();
      chk("pp_x16", w_addr, 5'd16);
      chk("pp_d16", w_data, 32'h0000_0002);
      tick();
      chk("pp_idle", w_en, 1'b0);

      // Fill FIFO, then reset between edges
      set_alu(1'b1, 5'd10, 32'h0000_0010);
      set_ld(1'b1, 5'd11, 32'h0000_00AA, 3'b010, 2'd0);
      tick();
      set_alu(1'b1, 5'd12, 32'h0000_0012);
      set_ld(1'b1, 5'd13, 32'h0000_00BB, 3'b010, 2'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      chk("full_ready", ld_ready, 1'b0);
      chk("full_en", w_en, 1'b1);
      q_addr = 5'd11;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en", w_en, 1'b0);
      chk("mid_rst_ready", ld_ready, 1'b1);
      chk("mid_rst_pending", q_pending, 1'b0);
      chk("mid_rst_data", w_data, 32'h0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_write", w_en, 1'b0);
      end

      // Random traffic against the scoreboard
      p_alu_v = 1'b0;
      p_alu_rd = 5'd0;
      p_alu_data = 32'h0;
      for (int i = 0; i < 1000; i++) begin
         set_alu(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
         set_ld(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         if (ld_valid && ld_ready && (ld_rd != 5'd0))
            exp_q.push_back({ld_rd, fmt(ld_funct3, ld_word, ld_offset)});
         p_alu_v    = alu_valid;
         p_alu_rd   = alu_rd;
         p_alu_data = alu_data;
         tick();
         rnd_check();
      end
      set_alu(1'b0, 5'd0, 32'h0);
      set_ld(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
      p_alu_v = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         rnd_check();
      end
      chk("rnd_all_loads_written", exp_q.size(), 0);
      chk("rnd_final_ready", ld_ready, 1'b1);
      chk("rnd_final_en", w_en, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
